// File: rtl/hazard_ctrl_pkg.sv
// Shared types for the pipeline hazard controller: forward-select encodings,
// FSM state encoding and the scoreboard entry layouts.
package hazard_ctrl_pkg;

  localparam int unsigned REG_W = 5;
  localparam int unsigned FWD_W = 2;

  // EX operand source select
  typedef enum logic [FWD_W-1:0] {
    FWD_REG = 2'd0,
    FWD_MEM = 2'd1,
    FWD_WB  = 2'd2
  } fwd_sel_e;

  // REDIR is observational only; hazard checks behave as in RUN
  typedef enum logic [1:0] {
    ST_RUN      = 2'd0,
    ST_LU_STALL = 2'd1,
    ST_REDIR    = 2'd2
  } state_e;

  // In-flight destination tracking common to every stage
  typedef struct packed {
    logic             v;
    logic             rw;
    logic             m2r;
    logic [REG_W-1:0] dst;
  } sb_entry_t;

  // EX entry additionally keeps its sources for the forwarding muxes
  typedef struct packed {
    sb_entry_t        e;
    logic             use_rs;
    logic             use_rt;
    logic [REG_W-1:0] rs;
    logic [REG_W-1:0] rt;
  } ex_entry_t;

  localparam sb_entry_t SB_BUBBLE = '0;
  localparam ex_entry_t EX_BUBBLE = '0;

endpackage

// File: rtl/hazard_ctrl_match.sv
// Combinational "entry writes register r" comparator. Register 0 never matches.
// Ports: entry_i scoreboard entry, reg_i register number, hit_o match flag.
module hazard_match
  import hazard_ctrl_pkg::*;
(
  input  sb_entry_t        entry_i,
  input  logic [REG_W-1:0] reg_i,
  output logic             hit_o
);

  // load flag is irrelevant to a plain write match
  logic unused_m2r;
  assign unused_m2r = entry_i.m2r;

  assign hit_o = entry_i.v & entry_i.rw & (entry_i.dst == reg_i) & (reg_i != '0);

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller for the 5-stage core: shadow scoreboard of
// in-flight destinations, per-stage stall/flush, EX forwarding and ID bypass
// selects, and stall/flush performance counters.
// Ports: clk_i/reset_i (sync, active-high); id_* decoded ID instruction;
// jump_ex_i/branch_taken_i redirects; mem_busy_i global freeze;
// stall_*_o/flush_*_o combinational pipeline controls; fwd_*_o/byp_*_o
// operand selects; stall_cnt_o/flush_cnt_o registered counters.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
#(
  parameter bit          FWD_EN = 1'b1,
  parameter int unsigned CNT_W  = 32
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             id_valid_i,
  input  logic [REG_W-1:0] id_rs_i,
  input  logic [REG_W-1:0] id_rt_i,
  input  logic             id_use_rs_i,
  input  logic             id_use_rt_i,
  input  logic             id_regwrite_i,
  input  logic             id_memtoreg_i,
  input  logic [REG_W-1:0] id_dst_i,
  input  logic             jump_ex_i,
  input  logic             branch_taken_i,
  input  logic             mem_busy_i,
  output logic             stall_if_o,
  output logic             stall_id_o,
  output logic             stall_ex_o,
  output logic             stall_mem_o,
  output logic             flush_id_o,
  output logic             flush_ex_o,
  output logic             flush_mem_o,
  output logic [FWD_W-1:0] fwd_a_o,
  output logic [FWD_W-1:0] fwd_b_o,
  output logic             byp_a_o,
  output logic             byp_b_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  state_e     state_q, state_d;
  ex_entry_t  ex_q, ex_d, id_entry;
  sb_entry_t  mem_q, mem_d, wb_q, wb_d;
  logic [CNT_W-1:0] stall_cnt_q, flush_cnt_q;
  logic       flush_evt;
  logic       raw;
  fwd_sel_e   fwd_a, fwd_b;

  logic ex_hit_rs, ex_hit_rt, mem_hit_rs, mem_hit_rt, wb_hit_rs, wb_hit_rt;
  logic mem_hit_exrs, mem_hit_exrt, wb_hit_exrs, wb_hit_exrt;
  logic rd_rs, rd_rt, ex_dep, mem_dep, wb_dep;

  // ex source use bits travel with the entry but forwarding keys off rs/rt only
  logic unused_ex_use;
  assign unused_ex_use = ex_q.use_rs ^ ex_q.use_rt;

  // Matches of ID sources against every in-flight stage
  hazard_match u_ex_rs  (.entry_i(ex_q.e), .reg_i(id_rs_i), .hit_o(ex_hit_rs));
  hazard_match u_ex_rt  (.entry_i(ex_q.e), .reg_i(id_rt_i), .hit_o(ex_hit_rt));
  hazard_match u_mem_rs (.entry_i(mem_q),  .reg_i(id_rs_i), .hit_o(mem_hit_rs));
  hazard_match u_mem_rt (.entry_i(mem_q),  .reg_i(id_rt_i), .hit_o(mem_hit_rt));
  hazard_match u_wb_rs  (.entry_i(wb_q),   .reg_i(id_rs_i), .hit_o(wb_hit_rs));
  hazard_match u_wb_rt  (.entry_i(wb_q),   .reg_i(id_rt_i), .hit_o(wb_hit_rt));

  // Matches of EX sources against MEM/WB producers for forwarding
  hazard_match u_mem_exrs (.entry_i(mem_q), .reg_i(ex_q.rs), .hit_o(mem_hit_exrs));
  hazard_match u_mem_exrt (.entry_i(mem_q), .reg_i(ex_q.rt), .hit_o(mem_hit_exrt));
  hazard_match u_wb_exrs  (.entry_i(wb_q),  .reg_i(ex_q.rs), .hit_o(wb_hit_exrs));
  hazard_match u_wb_exrt  (.entry_i(wb_q),  .reg_i(ex_q.rt), .hit_o(wb_hit_exrt));

  // Decoded ID instruction as a scoreboard entry
  always_comb begin
    id_entry       = EX_BUBBLE;
    id_entry.e.v   = id_valid_i;
    id_entry.e.rw  = id_regwrite_i;
    id_entry.e.m2r = id_memtoreg_i;
    id_entry.e.dst = id_dst_i;
    id_entry.use_rs = id_use_rs_i;
    id_entry.use_rt = id_use_rt_i;
    id_entry.rs    = id_rs_i;
    id_entry.rt    = id_rt_i;
  end

  // RAW detection; an invalid ID slot reads nothing
  assign rd_rs   = id_valid_i & id_use_rs_i;
  assign rd_rt   = id_valid_i & id_use_rt_i;
  assign ex_dep  = (ex_hit_rs  & rd_rs) | (ex_hit_rt  & rd_rt);
  assign mem_dep = (mem_hit_rs & rd_rs) | (mem_hit_rt & rd_rt);
  assign wb_dep  = (wb_hit_rs  & rd_rs) | (wb_hit_rt  & rd_rt);

  always_comb begin
    raw = 1'b0;
    if (FWD_EN) raw = ex_q.e.m2r & ex_dep;
    else        raw = ex_dep | mem_dep | wb_dep;
  end

  // Next-state and stall/flush outputs, priority busy > branch > jump > RAW
  always_comb begin
    state_d     = ST_RUN;
    wb_d        = mem_q;
    mem_d       = ex_q.e;
    ex_d        = id_valid_i ? id_entry : EX_BUBBLE;
    flush_evt   = 1'b0;
    stall_if_o  = 1'b0;
    stall_id_o  = 1'b0;
    stall_ex_o  = 1'b0;
    stall_mem_o = 1'b0;
    flush_id_o  = 1'b0;
    flush_ex_o  = 1'b0;
    flush_mem_o = 1'b0;
    if (mem_busy_i) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      stall_ex_o  = 1'b1;
      stall_mem_o = 1'b1;
      state_d     = state_q;
      wb_d        = wb_q;
      mem_d       = mem_q;
      ex_d        = ex_q;
    end else if (branch_taken_i) begin
      flush_id_o  = 1'b1;
      flush_ex_o  = 1'b1;
      flush_mem_o = 1'b1;
      mem_d       = SB_BUBBLE;
      ex_d        = EX_BUBBLE;
      state_d     = ST_REDIR;
      flush_evt   = 1'b1;
    end else if (jump_ex_i) begin
      flush_id_o  = 1'b1;
      flush_ex_o  = 1'b1;
      ex_d        = EX_BUBBLE;
      state_d     = ST_REDIR;
      flush_evt   = 1'b1;
    end else if (raw) begin
      stall_if_o  = 1'b1;
      stall_id_o  = 1'b1;
      flush_ex_o  = 1'b1;
      ex_d        = EX_BUBBLE;
      state_d     = FWD_EN ? ST_LU_STALL : ST_RUN;
    end
  end

  // Forwarding selects; MEM beats WB, loads in MEM cannot forward yet
  always_comb begin
    fwd_a = FWD_REG;
    fwd_b = FWD_REG;
    if (FWD_EN) begin
      if (mem_hit_exrs & ~mem_q.m2r) fwd_a = FWD_MEM;
      else if (wb_hit_exrs)          fwd_a = FWD_WB;
      if (mem_hit_exrt & ~mem_q.m2r) fwd_b = FWD_MEM;
      else if (wb_hit_exrt)          fwd_b = FWD_WB;
    end
  end

  assign fwd_a_o = fwd_a;
  assign fwd_b_o = fwd_b;
  assign byp_a_o = FWD_EN & id_use_rs_i & wb_hit_rs;
  assign byp_b_o = FWD_EN & id_use_rt_i & wb_hit_rt;

  // State, scoreboard and counters
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      state_q     <= ST_RUN;
      ex_q        <= EX_BUBBLE;
      mem_q       <= SB_BUBBLE;
      wb_q        <= SB_BUBBLE;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      ex_q        <= ex_d;
      mem_q       <= mem_d;
      wb_q        <= wb_d;
      stall_cnt_q <= stall_cnt_q + CNT_W'(stall_if_o);
      flush_cnt_q <= flush_cnt_q + CNT_W'(flush_evt);
    end
  end

  assign stall_cnt_o = stall_cnt_q;
  assign flush_cnt_o = flush_cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: two instances (forwarding on / off) share one
// directed stimulus stream; a pipeline-level model checks every cycle and
// literal expectations pin key points of each scenario.
module tb_hazard_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset, id_valid, id_use_rs, id_use_rt, id_regwrite, id_memtoreg;
  logic [4:0] id_rs, id_rt, id_dst;
  logic       jump_ex, branch_taken, mem_busy;

  logic u1_sif, u1_sid, u1_sex, u1_smem, u1_fid, u1_fex, u1_fmem, u1_bya, u1_byb;
  logic u0_sif, u0_sid, u0_sex, u0_smem, u0_fid, u0_fex, u0_fmem, u0_bya, u0_byb;
  logic [1:0]  u1_fwa, u1_fwb, u0_fwa, u0_fwb;
  logic [31:0] u1_scnt, u1_fcnt;
  logic [15:0] u0_scnt, u0_fcnt;

  hazard_ctrl #(.FWD_EN(1'b1), .CNT_W(32)) u1 (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_regwrite_i(id_regwrite),
    .id_memtoreg_i(id_memtoreg), .id_dst_i(id_dst), .jump_ex_i(jump_ex),
    .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
    .stall_if_o(u1_sif), .stall_id_o(u1_sid), .stall_ex_o(u1_sex), .stall_mem_o(u1_smem),
    .flush_id_o(u1_fid), .flush_ex_o(u1_fex), .flush_mem_o(u1_fmem),
    .fwd_a_o(u1_fwa), .fwd_b_o(u1_fwb), .byp_a_o(u1_bya), .byp_b_o(u1_byb),
    .stall_cnt_o(u1_scnt), .flush_cnt_o(u1_fcnt));

  hazard_ctrl #(.FWD_EN(1'b0), .CNT_W(16)) u0 (
    .clk_i(clk), .reset_i(reset), .id_valid_i(id_valid), .id_rs_i(id_rs), .id_rt_i(id_rt),
    .id_use_rs_i(id_use_rs), .id_use_rt_i(id_use_rt), .id_regwrite_i(id_regwrite),
    .id_memtoreg_i(id_memtoreg), .id_dst_i(id_dst), .jump_ex_i(jump_ex),
    .branch_taken_i(branch_taken), .mem_busy_i(mem_busy),
    .stall_if_o(u0_sif), .stall_id_o(u0_sid), .stall_ex_o(u0_sex), .stall_mem_o(u0_smem),
    .flush_id_o(u0_fid), .flush_ex_o(u0_fex), .flush_mem_o(u0_fmem),
    .fwd_a_o(u0_fwa), .fwd_b_o(u0_fwb), .byp_a_o(u0_bya), .byp_b_o(u0_byb),
    .stall_cnt_o(u0_scnt), .flush_cnt_o(u0_fcnt));

  // DUT observations indexed by configuration (1 = forwarding on)
  logic [6:0]  d_sf  [2];
  logic [3:0]  d_fwd [2];
  logic [1:0]  d_byp [2];
  logic [31:0] d_sc  [2];
  logic [31:0] d_fc  [2];
  logic [1:0]  d_st  [2];
  assign d_sf[1]  = {u1_sif, u1_sid, u1_sex, u1_smem, u1_fid, u1_fex, u1_fmem};
  assign d_sf[0]  = {u0_sif, u0_sid, u0_sex, u0_smem, u0_fid, u0_fex, u0_fmem};
  assign d_fwd[1] = {u1_fwa, u1_fwb};
  assign d_fwd[0] = {u0_fwa, u0_fwb};
  assign d_byp[1] = {u1_bya, u1_byb};
  assign d_byp[0] = {u0_bya, u0_byb};
  assign d_sc[1]  = u1_scnt;
  assign d_sc[0]  = {16'd0, u0_scnt};
  assign d_fc[1]  = u1_fcnt;
  assign d_fc[0]  = {16'd0, u0_fcnt};
  assign d_st[1]  = u1.state_q;
  assign d_st[0]  = u0.state_q;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- model: instructions flowing through EX, MEM, WB ----------
  typedef struct {
    bit v, rw, m2r, urs, urt;
    int dst, rs, rt;
  } ent_t;

  ent_t    pipe [2][3];          // [cfg][0=EX,1=MEM,2=WB]
  int      mst  [2];             // 0 run, 1 load-use stall, 2 redirect
  longint  mscnt[2], mfcnt[2];
  bit      live = 1'b0;

  function automatic bit writes(ent_t e, int r);
    return e.v && e.rw && (e.dst == r) && (r != 0);
  endfunction

  function automatic bit reads_from(ent_t e, ent_t id);
    return (id.v && id.urs && writes(e, id.rs)) || (id.v && id.urt && writes(e, id.rt));
  endfunction

  function automatic int fsel(int c, int src);
    if (c == 0) return 0;
    if (writes(pipe[c][1], src) && !pipe[c][1].m2r) return 1;
    if (writes(pipe[c][2], src)) return 2;
    return 0;
  endfunction

  ent_t bub;
  ent_t idn;

  always @(negedge clk) begin
    idn = '{v: id_valid, rw: id_regwrite, m2r: id_memtoreg, urs: id_use_rs, urt: id_use_rt,
            dst: int'(id_dst), rs: int'(id_rs), rt: int'(id_rt)};
    bub = '{default: 0};
    for (int c = 0; c < 2; c++) begin
      int act;
      bit raw;
      bit [6:0] sf;
      bit [3:0] fw;
      bit [1:0] by;
      longint mask;
      mask = (c == 1) ? 64'hFFFF_FFFF : 64'hFFFF;
      if (c == 1) raw = pipe[c][0].m2r && reads_from(pipe[c][0], idn);
      else raw = reads_from(pipe[c][0], idn) || reads_from(pipe[c][1], idn) ||
                 reads_from(pipe[c][2], idn);
      if (mem_busy)          begin act = 0; sf = 7'b1111_000; end
      else if (branch_taken) begin act = 1; sf = 7'b0000_111; end
      else if (jump_ex)      begin act = 2; sf = 7'b0000_110; end
      else if (raw)          begin act = 3; sf = 7'b1100_010; end
      else                   begin act = 4; sf = 7'b0000_000; end
      fw = {2'(fsel(c, pipe[c][0].rs)), 2'(fsel(c, pipe[c][0].rt))};
      by = {c == 1 && id_use_rs && writes(pipe[c][2], idn.rs),
            c == 1 && id_use_rt && writes(pipe[c][2], idn.rt)};
      if (live) begin
        chk($sformatf("u%0d stall_flush", c), d_sf[c], sf);
        chk($sformatf("u%0d fwd", c), d_fwd[c], fw);
        chk($sformatf("u%0d byp", c), d_byp[c], by);
        chk($sformatf("u%0d stall_cnt", c), d_sc[c], mscnt[c] & mask);
        chk($sformatf("u%0d flush_cnt", c), d_fc[c], mfcnt[c] & mask);
        chk($sformatf("u%0d state", c), d_st[c], mst[c]);
      end
      if (reset) begin
        pipe[c][0] = bub; pipe[c][1] = bub; pipe[c][2] = bub;
        mst[c] = 0; mscnt[c] = 0; mfcnt[c] = 0;
      end else begin
        if (sf[6]) mscnt[c]++;
        case (act)
          1: begin pipe[c][2] = pipe[c][1]; pipe[c][1] = bub; pipe[c][0] = bub;
                   mst[c] = 2; mfcnt[c]++; end
          2: begin pipe[c][2] = pipe[c][1]; pipe[c][1] = pipe[c][0]; pipe[c][0] = bub;
                   mst[c] = 2; mfcnt[c]++; end
          3: begin pipe[c][2] = pipe[c][1]; pipe[c][1] = pipe[c][0]; pipe[c][0] = bub;
                   mst[c] = (c == 1) ? 1 : 0; end
          4: begin pipe[c][2] = pipe[c][1]; pipe[c][1] = pipe[c][0];
                   pipe[c][0] = idn.v ? idn : bub; mst[c] = 0; end
          default: ;
        endcase
      end
    end
    if (reset) live = 1'b1;
  end

  // ---------------- stimulus helpers ----------------
  task automatic id_in(input bit v, input int rs, input int rt, input bit urs, input bit urt,
                       input bit rw, input bit m2r, input int dst);
    id_valid = v; id_rs = 5'(rs); id_rt = 5'(rt); id_use_rs = urs; id_use_rt = urt;
    id_regwrite = rw; id_memtoreg = m2r; id_dst = 5'(dst);
  endtask
  task automatic nop();                          id_in(0, 0, 0, 0, 0, 0, 0, 0);     endtask
  task automatic ld(input int d, input int b);   id_in(1, b, d, 1, 0, 1, 1, d);     endtask
  task automatic alu(input int d, input int s, input int t); id_in(1, s, t, 1, 1, 1, 0, d); endtask
  task automatic alui(input int d, input int s); id_in(1, s, d, 1, 0, 1, 0, d);     endtask
  task automatic settle(); #2; endtask
  task automatic tick();   @(posedge clk); #1; endtask

  initial begin
    reset = 1'b1; jump_ex = 1'b0; branch_taken = 1'b0; mem_busy = 1'b0;
    nop();
    tick(); tick();
    reset = 1'b0;

    // Load-use: lw $2 ; add $3,$2,$4
    ld(2, 1); settle(); chk("reset stall_if", u1_sif, 0); tick();
    alu(3, 2, 4); settle();
    chk("lu stall", {u1_sif, u1_sid, u1_sex, u1_fex}, 4'b1101); tick();
    alu(3, 2, 4); settle();
    chk("lu released", u1_sif, 0);
    chk("lu state", u1.state_q, 2'd1);
    chk("lu stall_cnt", u1_scnt, 1); tick();
    nop(); settle();
    chk("lu fwd_a wb", u1_fwa, 2'd2);
    chk("lu fwd_b", u1_fwb, 2'd0);
    chk("lu back to run", u1.state_q, 2'd0); tick();
    repeat (3) begin nop(); tick(); end

    // ALU chain: two writers of $2 then sub $5,$2,$2 ; MEM wins
    alui(2, 1); tick();
    alui(2, 1); tick();
    alu(5, 2, 2); settle(); chk("alu no stall", u1_sif, 0); tick();
    nop(); settle(); chk("fwd mem wins", {u1_fwa, u1_fwb}, 4'b0101); tick();

    // $7 producer in WB while consumer in ID
    alui(7, 1); tick();
    nop(); tick();
    nop(); tick();
    alu(11, 7, 7); settle();
    chk("byp $7", {u1_bya, u1_byb}, 2'b11);
    chk("byp no stall", u1_sif, 0); tick();

    // Writes to $0 never hazard
    alui(0, 1); tick();
    alu(8, 0, 0); settle(); chk("r0 no stall", {u1_sif, u0_sif}, 2'b00); tick();
    alu(9, 0, 0); settle(); chk("r0 fwd", {u1_fwa, u1_fwb}, 4'b0000); tick();
    alu(10, 0, 0); settle(); chk("r0 byp", {u1_bya, u1_byb}, 2'b00); tick();
    repeat (3) begin nop(); tick(); end

    // Branch taken over a load-use hazard
    ld(2, 1); tick();
    alu(3, 2, 4); branch_taken = 1'b1; settle();
    chk("br flush", {u1_fid, u1_fex, u1_fmem, u1_sif}, 4'b1110);
    chk("br flush u0", {u0_fid, u0_fex, u0_fmem, u0_sif}, 4'b1110); tick();
    branch_taken = 1'b0; alu(3, 2, 4); settle();
    chk("br no spurious", {u1_sif, u0_sif}, 2'b00);
    chk("br flush_cnt", u1_fcnt, 1);
    chk("br redir", u1.state_q, 2'd2); tick();
    repeat (3) begin nop(); tick(); end

    // mem_busy freeze with a pending jump
    reset = 1'b1; tick(); reset = 1'b0;
    mem_busy = 1'b1; jump_ex = 1'b1;
    for (int i = 0; i < 3; i++) begin
      settle();
      chk("busy stalls", {u1_sif, u1_sid, u1_sex, u1_smem}, 4'hF);
      chk("busy no flush", {u1_fid, u1_fex, u1_fmem}, 3'b000);
      tick();
    end
    mem_busy = 1'b0; settle();
    chk("jump flush", {u1_fid, u1_fex, u1_fmem, u1_sif}, 4'b1100);
    chk("busy stall_cnt", u1_scnt, 3); tick();
    jump_ex = 1'b0; settle();
    chk("jump flush_cnt", u1_fcnt, 1);
    chk("jump stall_cnt", u1_scnt, 3);
    chk("u0 jump flush_cnt", u0_fcnt, 1); tick();

    // No forwarding: producer stalls consumer through EX, MEM, WB
    alui(2, 1); tick();
    for (int i = 0; i < 3; i++) begin
      alu(3, 2, 4); settle();
      chk("nofwd stall", u0_sif, 1);
      chk("nofwd sel", {u0_fwa, u0_fwb, u0_bya, u0_byb}, 6'd0); tick();
    end
    alu(3, 2, 4); settle();
    chk("nofwd release", u0_sif, 0);
    chk("nofwd stall_cnt", u0_scnt, 6); tick();
    nop(); tick();

    // Reset in the middle of a stall
    alui(2, 1); tick();
    alu(3, 2, 4); tick();
    reset = 1'b1; settle(); chk("pre-reset stall", u0_sif, 1); tick();
    reset = 1'b0; settle();
    chk("post-reset outs", {u0_sif, u0_sid, u0_sex, u0_smem, u0_fid, u0_fex, u0_fmem,
                            u0_fwa, u0_fwb, u0_bya, u0_byb}, 13'd0);
    chk("post-reset u0 cnt", {u0_scnt, u0_fcnt}, 32'd0);
    chk("post-reset u1 cnt", {u1_scnt, u1_fcnt}, 64'd0); tick();
    nop(); tick(); tick();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
Pipeline hazard controller for the 5-stage MIPS core (IF/ID/EX/MEM/WB). It tracks in-flight destination registers in a shadow scoreboard and generates per-stage stall, flush and forward/bypass selects. It sits beside the pipeline registers; the decode stage feeds it decoded operand and destination information, and the EX and MEM stages feed it redirect events. It also keeps stall and flush performance counters.

Parameters:
FWD_EN, 1, 1 = EX forwarding and ID bypass enabled; 0 = stall on every RAW hazard, fwd/byp outputs forced to 0
CNT_W, 32, width of the stall and flush performance counters

Ports:
clk  in  1  core clock, all state on rising edge
reset  in  1  synchronous, active-high
id_valid  in  1  ID holds a real instruction
id_rs  in  5  ID source register A
id_rt  in  5  ID source register B
id_use_rs  in  1  ID instruction reads rs
id_use_rt  in  1  ID instruction reads rt
id_regwrite  in  1  ID instruction writes the regfile
id_memtoreg  in  1  ID instruction is a load
id_dst  in  5  ID destination, already resolved from regdst/link
jump_ex  in  1  jump or jr resolved in EX this cycle
branch_taken  in  1  branch resolved taken in MEM this cycle
mem_busy  in  1  data memory not ready; freeze the whole pipeline
stall_if  out  1  hold PC
stall_id  out  1  hold IF/ID
stall_ex  out  1  hold ID/EX
stall_mem  out  1  hold EX/MEM and MEM/WB
flush_id  out  1  load bubble into IF/ID
flush_ex  out  1  load bubble into ID/EX
flush_mem  out  1  load bubble into EX/MEM
fwd_a  out  2  EX operand A select: 0 = regfile, 1 = MEM ALU result, 2 = WB writedata
fwd_b  out  2  EX operand B select, same encoding
byp_a  out  1  ID regdataa takes WB writedata
byp_b  out  1  ID regdatab takes WB writedata
stall_cnt  out  CNT_W  cycles with stall_if = 1
flush_cnt  out  CNT_W  redirect events

Behaviour:
- Scoreboard: three registered entries ex_q, mem_q and wb_q. Each entry holds {v, rw, m2r, dst}. ex_q also holds rs/rt with their use bits.
- "Writes r": v & rw & dst == r & r != 0. Register 0 never causes a hazard.
- Normal advance each cycle: wb_q <= mem_q, mem_q <= ex_q, ex_q <= ID entry. The ID entry is loaded only when id_valid = 1; otherwise a bubble is loaded.
- FSM states:
  - RUN (reset state)
  - LU_STALL: one-cycle load-use stall
  - REDIR: first cycle after a redirect; hazard checks run normally. This state exists for debug and timing only.
- Priority, highest first. Exactly one of these actions applies per cycle.
  1. mem_busy. All four stalls = 1, all flushes = 0. Scoreboard and FSM hold. jump_ex and branch_taken are ignored; their sources hold them until unfrozen.
  2. branch_taken. flush_id = flush_ex = flush_mem = 1. ex_q and mem_q next become bubbles (wb_q <= mem_q as normal). FSM -> REDIR. flush_cnt += 1.
  3. jump_ex. flush_id = flush_ex = 1. ex_q next becomes a bubble. FSM -> REDIR. flush_cnt += 1.
  4. RAW stall. stall_if = stall_id = 1 and flush_ex = 1 (bubble into EX); ex_q next becomes a bubble. FSM -> LU_STALL when FWD_EN = 1, otherwise stays in RUN.
     - FWD_EN = 1: RAW stall when ex_q is a load that writes a used ID source.
     - FWD_EN = 0: RAW stall when any of ex_q, mem_q or wb_q writes a used ID source.
  5. Otherwise no stall or flush. FSM -> RUN.
- LU_STALL always returns to RUN or REDIR the next cycle. A load-use hazard against one producer never stalls more than 1 cycle.
- Stall and flush outputs are combinational from the scoreboard and inputs. Nothing is registered on the output.
- fwd_a, when FWD_EN = 1:
  - 1 if mem_q writes ex rs and mem_q.m2r = 0;
  - else 2 if wb_q writes ex rs;
  - else 0.
  - fwd_b uses the same rule on ex rt. MEM takes precedence over WB.
- byp_a = FWD_EN & id_use_rs & wb_q writes id_rs. byp_b is the same on rt.
- Counters wrap modulo 2^CNT_W. stall_cnt counts every cycle with stall_if = 1, including mem_busy cycles.
- Reset: all scoreboard entries v = 0, FSM = RUN, counters = 0. All outputs then read 0 because the entries are invalid.
- Reset during a stall or flush clears everything in the same edge. No pending redirect survives reset.

Decomposition:
- Shared package: fwd-select encodings (FWD_REG, FWD_MEM, FWD_WB), FSM state encoding, and the scoreboard entry struct/width constants.
- One sub-module, hazard_match: a combinational "entry writes register r" comparator, instantiated per (entry, source) pair.

Test Plan:
- FWD_EN = 1: lw $2 then add $3,$2,$4 back-to-back -> stall_if/stall_id/flush_ex = 1 for exactly 1 cycle, FSM passes LU_STALL, then fwd_a = 2 when add reaches EX; stall_cnt = 1.
- add $2,... then sub $5,$2,$2 -> no stall; fwd_a = fwd_b = 1 in sub's EX cycle. With a second writer of $2 in WB at the same time, fwd remains 1 (MEM wins).
- Producer of $7 in WB while the consumer is in ID -> byp_a = 1 for that cycle. A write to $0 anywhere -> no stall, fwd = 0, byp = 0.
- branch_taken = 1 together with a load-use hazard in ID -> flush_id/flush_ex/flush_mem = 1, stall_if = 0, flush_cnt += 1; the next cycle's ex_q is invalid (no spurious hazard).
- mem_busy held for 3 cycles with jump_ex = 1 -> all four stalls = 1 for 3 cycles and no flush. On release, flush_id = flush_ex = 1 once; stall_cnt = 3, flush_cnt = 1.
- FWD_EN = 0: addi $2 followed by a $2 consumer -> 3 stall cycles (producer in EX, MEM, WB), fwd/byp always 0. Assert reset mid-stall -> all outputs 0 the next cycle and the counters cleared.
